cordic_stream_top: RTL and testbench
====================================

// Module: cordic_stream_top
// PURPOSE
//  Streaming single-precision sin/cos engine: IEEE-754 in -> signed fixed -> iterative CORDIC -> IEEE-754 out.
//  Successor to the fixed-width float->CORDIC->float top: parametrised word length and iteration count.
//  Adds per-transaction sin/cos mode, valid/ready handshakes on both sides, and an error flag.
//  Sits between the processor custom-instruction/bus adapter and software; one transaction in flight.
// PARAMETERS
//  WORD_LENGTH  21  fixed-point width, signed Q3.(WORD_LENGTH-3); FRAC = WORD_LENGTH-3 (legal 12..32)
//  ITERATIONS   16  CORDIC micro-rotations per transaction (legal 4..24, <= FRAC)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   input word valid
//  in_ready   out  1   block can accept input this cycle
//  in_data    in   32  IEEE-754 single, angle in radians
//  in_mode    in   1   0 = cos, 1 = sin; sampled with in_data
//  out_valid  out  1   result valid, held until accepted
//  out_ready  in   1   consumer accepts result
//  out_data   out  32  IEEE-754 single result
//  out_err    out  1   result flagged (NaN/Inf input or |x| >= 2.0); valid with out_valid
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_data=0, out_err=0, busy=0, iteration counter=0; in_ready=0 while rst high.
//  Reset mid-operation: transaction discarded silently, no output produced.
//  FSM: IDLE -> ROTATE -> PACK -> DONE -> (IDLE | ROTATE).
//   in_ready = (state==IDLE) | (state==DONE & out_ready); input accepted on edge with in_valid & in_ready.
//   Accept edge E0: float->fixed into z, x=K, y=0, mode latched, err latched; -> ROTATE, cnt=0.
//   ROTATE: one micro-rotation per cycle, i=cnt; d=sign(z); x-=d*(y>>>i); y+=d*(x>>>i); z-=d*atan[i].
//    After i=ITERATIONS-1 -> PACK. Shifts arithmetic; all adds WORD_LENGTH wide, wrap, no extension.
//   PACK: selected x (cos) or y (sin) -> float into out_data; -> DONE, out_valid=1.
//   out_valid first seen after edge E0+ITERATIONS+1 (latency ITERATIONS+1 cycles).
//   DONE: outputs stable while out_valid & !out_ready. On out_ready: with simultaneous accept -> ROTATE
//    (back-to-back, period ITERATIONS+2 cycles), else -> IDLE; out_valid drops unless new result.
//  Constants: K = round(0.6072529350 * 2^FRAC); atan[i] = round(atan(2^-i) * 2^FRAC), ITERATIONS-entry ROM.
//  Float->fixed: exp==0 (zero/denormal) -> 0. exp==255 (Inf/NaN) -> err=1, out_data forced 0x7FC00000.
//   |x| >= 2.0 -> z saturates to +/-(2^(WORD_LENGTH-1)-1), err=1, result still computed.
//   Otherwise shift mantissa by exp-127 into Q3.FRAC, truncate toward zero, apply sign.
//  Fixed->float: 0 -> 0x00000000. Else sign/magnitude, leading-one detect, exp=127+pos-FRAC,
//   mantissa truncated to 23 bits. Magnitude > 1.0 from CORDIC gain error passed through unclamped.
//  in_mode / in_data ignored unless accepted; mode change mid-transaction has no effect.
//  Accuracy: |result - ref| <= 2^-(ITERATIONS-2) for |x| <= pi/2, default parameters.
// TESTING
//  1 cos(0): in 0x00000000, mode 0 -> 0x3F800000 +/-tol, out_err=0, out_valid after exactly 17 cycles.
//  2 sin(pi/6): in 0x3F060A92, mode 1 -> ~0x3F000000 within tol; sin(-pi/6) -> sign bit set.
//  3 Back-pressure: out_ready low 10 cycles -> out_data/out_valid stable, in_ready=0; then accept.
//  4 Back-to-back: in_valid held high, out_ready=1 -> accepts every 18 cycles, no lost/duplicated results.
//  5 Errors: 0x7F800000 -> 0x7FC00000, err=1; 0x40400000 (3.0) -> err=1, saturated result, no hang.
//  6 Reset mid-ROTATE (cycle 5) -> out_valid=0, IDLE, in_ready=1 after release, next txn correct.

Source files
------------

// File: rtl/cordic_stream_top.sv
// Streaming IEEE-754 single sin/cos engine: float -> Q3.FRAC -> iterative CORDIC -> float.
// One transaction in flight, valid/ready on both sides, error flag for NaN/Inf and |x| >= 2.
module cordic_stream_top #(
    parameter int WORD_LENGTH = 21,
    parameter int ITERATIONS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        busy
);
    localparam int FRAC  = WORD_LENGTH - 3;
    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    // atan(2^-i) with 62 fractional bits; the series terms are exact powers of two over odd divisors
    function automatic logic [63:0] atan62(input int i);
        logic [63:0] acc;
        logic [63:0] term;
        int          sh;
        acc = '0;
        if (i == 0) begin
            acc = 64'h3243F6A8885A308D;
        end else begin
            for (int k = 0; k < 32; k++) begin
                sh = 62 - i * (2 * k + 1);
                if (sh >= 0) begin
                    term = (64'd1 << sh) / 64'(2 * k + 1);
                    if (k % 2 == 0) acc = acc + term;
                    else            acc = acc - term;
                end
            end
        end
        return acc;
    endfunction

    function automatic logic [ITERATIONS-1:0][WORD_LENGTH-1:0] gen_atan();
        logic [ITERATIONS-1:0][WORD_LENGTH-1:0] t;
        logic [63:0] r;
        for (int i = 0; i < ITERATIONS; i++) begin
            r    = (atan62(i) + (64'd1 << (61 - FRAC))) >> (62 - FRAC);
            t[i] = WORD_LENGTH'(r);
        end
        return t;
    endfunction

    localparam logic [ITERATIONS-1:0][WORD_LENGTH-1:0] ATAN = gen_atan();
    localparam logic [63:0] K64 = ((64'd6072529350 << FRAC) + 64'd5000000000) / 64'd10000000000;
    localparam logic [WORD_LENGTH-1:0] K    = WORD_LENGTH'(K64);
    localparam logic [WORD_LENGTH-1:0] ZMAX = {1'b0, {(WORD_LENGTH-1){1'b1}}};

    // Truncates toward zero by shifting the magnitude, then applies the sign
    function automatic logic [WORD_LENGTH-1:0] to_fixed(input logic [31:0] f);
        logic [7:0]             e;
        logic [63:0]            mag;
        logic [WORD_LENGTH-1:0] m;
        int                     sh;
        e   = f[30:23];
        mag = {40'd0, 1'b1, f[22:0]};
        sh  = int'(e) - 150 + FRAC;
        if (e == 8'd0)     mag = '0;
        else if (sh >= 0)  mag = mag << sh;
        else               mag = mag >> (-sh);
        m = WORD_LENGTH'(mag);
        if (e[7]) m = ZMAX;
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] to_float(input logic [WORD_LENGTH-1:0] v);
        logic [WORD_LENGTH-1:0] mag;
        logic [63:0]            m64;
        logic [31:0]            res;
        int                     p;
        mag = v[WORD_LENGTH-1] ? -v : v;
        p   = 0;
        for (int b = 0; b < WORD_LENGTH; b++)
            if (mag[b]) p = b;
        m64 = {{(64-WORD_LENGTH){1'b0}}, mag};
        if (p <= 23) m64 = m64 << (23 - p);
        else         m64 = m64 >> (p - 23);
        res = {v[WORD_LENGTH-1], 8'(127 + p - FRAC), 23'(m64)};
        if (mag == '0) res = 32'd0;
        return res;
    endfunction

    typedef enum logic [1:0] {IDLE, ROTATE, PACK, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]              cnt;
    logic signed [WORD_LENGTH-1:0] x, y, z;
    logic signed [WORD_LENGTH-1:0] x_sh, y_sh, x_rot, y_rot, z_rot;
    logic                          mode, err, nan, accept, last, dpos;
    logic [7:0]                    in_exp;

    assign in_exp   = in_data[30:23];
    assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign last     = cnt == CNT_W'(ITERATIONS - 1);
    assign busy     = state != IDLE;

    // One micro-rotation; d = +1 when z >= 0
    assign dpos  = !z[WORD_LENGTH-1];
    assign x_sh  = x >>> cnt;
    assign y_sh  = y >>> cnt;
    assign x_rot = dpos ? x - y_sh : x + y_sh;
    assign y_rot = dpos ? y + x_sh : y - x_sh;
    assign z_rot = dpos ? z - $signed(ATAN[cnt]) : z + $signed(ATAN[cnt]);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ROTATE;
            ROTATE:  if (last) state_nx = PACK;
            PACK:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = accept ? ROTATE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            mode      <= 1'b0;
            err       <= 1'b0;
            nan       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                z    <= to_fixed(in_data);
                x    <= K;
                y    <= '0;
                mode <= in_mode;
                err  <= in_exp[7];
                nan  <= &in_exp;
                cnt  <= '0;
            end else if (state == ROTATE) begin
                x   <= x_rot;
                y   <= y_rot;
                z   <= z_rot;
                cnt <= cnt + 1'b1;
            end
            if (state == PACK) begin
                out_valid <= 1'b1;
                out_data  <= nan ? 32'h7FC00000 : to_float(mode ? y : x);
                out_err   <= err;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cordic_stream_top.sv
// Randomised bench for cordic_stream_top: real-math reference model, scoreboard and directed edge cases.
`timescale 1ns/1ps
module tb_cordic_stream_top;
    localparam int  ITER = 16;
    localparam real TOL  = 1.0 / 16384.0;

    logic        clk, rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_err, busy;
    logic [31:0] in_data, out_data;

    int checks = 0, errors = 0, nres = 0, exp_res = 0;
    logic [32:0] acc_q[$];

    cordic_stream_top #(.WORD_LENGTH(21), .ITERATIONS(ITER)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int i = 0; i < e - 127; i++) v = v * 2.0;
        for (int i = 0; i < 127 - e; i++) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  a;
        int   e;
        logic s;
        if (r == 0.0) return 32'd0;
        s = r < 0.0;
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 0) begin a = a * 2.0; e--; end
        if (e <= 0) return 32'd0;
        return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input real tol);
        bit bad;
        checks++;
        if (tol == 0.0) bad = (got !== exp);
        else            bad = !(rabs(f2r(got) - f2r(exp)) <= tol);
        if (bad) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Saturated inputs drive every rotation the same way, so the angle is the full atan sum
    task automatic model(input logic [32:0] t, output logic [31:0] d, output logic e, output real tol);
        logic [31:0] f;
        real a, p, sumat;
        f   = t[31:0];
        tol = TOL;
        e   = 1'b0;
        if (f[30:23] == 8'hFF) begin
            d = 32'h7FC00000; e = 1'b1; tol = 0.0;
            return;
        end
        if (f[30]) begin
            sumat = 0.0; p = 1.0;
            for (int i = 0; i < ITER; i++) begin sumat = sumat + $atan(p); p = p / 2.0; end
            a = f[31] ? -sumat : sumat; e = 1'b1; tol = 2.0 * TOL;
        end else begin
            a = f2r(f);
        end
        d = r2f(t[32] ? $sin(a) : $cos(a));
    endtask

    function automatic logic [31:0] rnd_in();
        logic [7:0]  e;
        logic [22:0] m;
        int          sel;
        sel = $urandom_range(0, 9);
        m   = 23'($urandom);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'hFF;
        else if (sel == 2) e = 8'($urandom_range(128, 131));
        else begin
            e = 8'($urandom_range(105, 127));
            if (e == 8'd127) m[22] = 1'b0;
        end
        return {1'($urandom), e, m};
    endfunction

    always @(posedge clk) begin
        logic [31:0] ed;
        logic        ee;
        real         tl;
        logic [32:0] t;
        if (rst) acc_q.delete();
        else begin
            if (in_valid && in_ready) acc_q.push_back({in_mode, in_data});
            if (out_valid && out_ready) begin
                nres++;
                check("sb_pending", 32'(acc_q.size() > 0), 32'd1, 0.0);
                if (acc_q.size() > 0) begin
                    t = acc_q.pop_front();
                    model(t, ed, ee, tl);
                    check("sb_data", out_data, ed, tl);
                    check("sb_err", {31'd0, out_err}, {31'd0, ee}, 0.0);
                end
            end
        end
    end

    task automatic put(input logic [31:0] d, input logic m);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_mode = m;
        for (int n = 0; n < 200 && !done; n++) begin
            #1 done = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0; in_data = $urandom; in_mode = 1'($urandom);
        if (!done) check("in_ready_timeout", {31'd0, in_ready}, 32'd1, 0.0);
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(posedge clk);
            #1 if (out_valid) lat = n;
        end
        if (lat < 0) check("out_valid_timeout", {31'd0, out_valid}, 32'd1, 0.0);
    endtask

    task automatic pop();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic txn(input logic [31:0] d, input logic m);
        int lat;
        put(d, m); exp_res++;
        wait_out(lat);
        check("latency", 32'(lat), 32'(ITER + 1), 0.0);
        pop();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, prev, n0;
        bit r;
        logic [31:0] bb[6];
        logic [31:0] ed;
        logic        ee;
        real         tl;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0, 0.0);
        check("rst_out_data", out_data, 32'd0, 0.0);
        check("rst_out_err", {31'd0, out_err}, 32'd0, 0.0);
        check("rst_busy", {31'd0, busy}, 32'd0, 0.0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0, 0.0);
        @(negedge clk); rst = 1'b0;
        #1 check("idle_in_ready", {31'd0, in_ready}, 32'd1, 0.0);

        // cos(0): exact latency, busy while working, valid drops after accept
        put(32'h00000000, 1'b0); exp_res++;
        check("busy_active", {31'd0, busy}, 32'd1, 0.0);
        wait_out(lat);
        check("cos0_latency", 32'(lat), 32'(ITER + 1), 0.0);
        check("cos0_value", out_data, 32'h3F800000, TOL);
        pop();
        check("valid_drop", {31'd0, out_valid}, 32'd0, 0.0);

        txn(32'h3F060A92, 1'b1);
        put(32'hBF060A92, 1'b1); exp_res++;
        wait_out(lat);
        check("sin_neg_sign", {31'd0, out_data[31]}, 32'd1, 0.0);
        pop();

        // Back-pressure: result held, no new input accepted
        put(32'h3F400000, 1'b0); exp_res++;
        wait_out(lat);
        model({1'b0, 32'h3F400000}, ed, ee, tl);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1, 0.0);
            check("bp_data", out_data, ed, tl);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0, 0.0);
        end
        pop();

        // Errors and zero/denormal handling
        txn(32'h7F800000, 1'b0);
        txn(32'h7FC00001, 1'b1);
        txn(32'h40400000, 1'b0);
        txn(32'hC0400000, 1'b1);
        txn(32'h00000001, 1'b0);

        // Back-to-back with in_valid held and out_ready high
        for (int i = 0; i < 6; i++) bb[i] = rnd_in();
        n0 = nres; k = 0; prev = 0;
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_data = bb[0]; in_mode = 1'b1;
        for (int n = 0; n < 6 * 18 + 60 && k < 6; n++) begin
            #1 r = in_ready;
            @(posedge clk);
            if (r) begin
                if (k > 0) check("b2b_period", 32'(n - prev), 32'(ITER + 2), 0.0);
                prev = n; k++;
            end
            @(negedge clk);
            if (k < 6) begin in_data = bb[k]; in_mode = 1'(k); end
            else in_valid = 1'b0;
        end
        check("b2b_accepts", 32'(k), 32'd6, 0.0);
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        check("b2b_drain", {31'd0, busy}, 32'd0, 0.0);
        check("b2b_results", 32'(nres - n0), 32'd6, 0.0);
        exp_res += 6;
        out_ready = 1'b0;

        // Reset in the middle of ROTATE discards the transaction
        put(32'h3F000000, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0, 0.0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0, 0.0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0, 0.0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1, 0.0);
        repeat (25) begin
            @(negedge clk);
            check("post_rst_no_out", {31'd0, out_valid}, 32'd0, 0.0);
        end
        txn(32'h3F000000, 1'b1);

        // Random traffic with random consumer delay
        for (int i = 0; i < 40; i++) begin
            put(rnd_in(), 1'($urandom)); exp_res++;
            wait_out(lat);
            check("rnd_latency", 32'(lat), 32'(ITER + 1), 0.0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pop();
        end

        repeat (3) @(negedge clk);
        check("result_count", 32'(nres), 32'(exp_res), 0.0);
        check("sb_empty", 32'(acc_q.size()), 32'd0, 0.0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
